// File: rtl/decoder_6_2.sv
// decoder_6_2: receive-side FNS CAC decoder.
// Rebuilds the data word as a weighted sum of the enabled codeword bits through a
// two-stage valid/ready pipeline, flags out-of-range sums and keeps a sticky,
// saturating error count for the repair controller.
module decoder_6_2 #(
  parameter int unsigned NBITS = 8,
  parameter int unsigned DW    = 6,
  parameter int unsigned WW    = 7,
  parameter int unsigned CW    = 8
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NBITS-1:0]    codein,
  input  logic [NBITS-1:0]    en_flag,
  input  logic [NBITS*WW-1:0] fns_w,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       dataout,
  output logic                out_err,
  output logic [CW-1:0]       err_cnt,
  input  logic                clr_err
);

  // Sum width covers NBITS full-scale weights without overflow.
  localparam int unsigned SW   = WW + $clog2(NBITS);
  localparam int unsigned DMAX = (1 << DW) - 1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic                s1_valid;
  logic [NBITS-1:0]    s1_cw;
  logic [NBITS*WW-1:0] s1_w;
  logic                s2_free;
  logic                s1_adv;
  logic                accept;
  logic [SW-1:0]       sum;
  logic                sum_err;

  // Handshake: stage 2 frees when empty or draining; stage 1 frees when empty or advancing.
  always_comb begin
    s2_free  = !out_valid || out_ready;
    s1_adv   = s1_valid && s2_free;
    in_ready = !s1_valid || s2_free;
    accept   = in_valid && in_ready;
  end

  // Weighted FNS sum of the masked codeword held in stage 1.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NBITS; i++) begin
      if (s1_cw[i]) begin
        sum = sum + SW'(s1_w[i*WW +: WW]);
      end
    end
    sum_err = (sum > SW'(DMAX));
  end

  // Stage 1: capture the masked codeword and its weights with the word.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
      s1_w     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_cw    <= codein & en_flag;
      s1_w     <= fns_w;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: register decoded word and range flag; hold while stalled.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dataout   <= '0;
      out_err   <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      dataout   <= sum[DW-1:0];
      out_err   <= sum_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Error counter: bumps as an error word enters stage 2, saturates; clear wins.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr_err) begin
      err_cnt <= '0;
    end else if (s1_adv && sum_err && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_decoder_6_2.sv
// tb_decoder_6_2: directed plus randomized checks of decoder_6_2 against an
// arithmetic reference model with an expected-output queue.
module tb_decoder_6_2;

  localparam int NBITS = 8;
  localparam int DW    = 6;
  localparam int WW    = 7;
  localparam int CW    = 8;

  logic                clock = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [NBITS-1:0]    codein;
  logic [NBITS-1:0]    en_flag;
  logic [NBITS*WW-1:0] fns_w;
  logic                out_valid;
  logic                out_ready;
  logic [DW-1:0]       dataout;
  logic                out_err;
  logic [CW-1:0]       err_cnt;
  logic                clr_err;

  decoder_6_2 dut (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .codein(codein), .en_flag(en_flag), .fns_w(fns_w), .out_valid(out_valid),
    .out_ready(out_ready), .dataout(dataout), .out_err(out_err),
    .err_cnt(err_cnt), .clr_err(clr_err)
  );

  always #5 clock = ~clock;

  typedef struct { int d; int e; } exp_t;

  int   w[NBITS];
  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   model_errs = 0;
  bit   last_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [NBITS*WW-1:0] pack_w();
    logic [NBITS*WW-1:0] r;
    r = '0;
    for (int i = 0; i < NBITS; i++) r[i*WW +: WW] = WW'(w[i]);
    return r;
  endfunction

  task automatic set_fib(input int w7);
    w[0] = 1; w[1] = 1; w[2] = 2; w[3] = 3; w[4] = 5; w[5] = 8; w[6] = 13; w[7] = w7;
    fns_w = pack_w();
  endtask

  // Reference: plain weighted sum of the bits that are both set and enabled.
  function automatic exp_t ref_word(input logic [NBITS-1:0] c, input logic [NBITS-1:0] e,
                                    input logic [NBITS*WW-1:0] f);
    exp_t r;
    int s;
    s = 0;
    for (int i = 0; i < NBITS; i++)
      if (c[i] && e[i]) s += int'(f[i*WW +: WW]);
    r.d = s % (1 << DW);
    r.e = (s > (1 << DW) - 1) ? 1 : 0;
    return r;
  endfunction

  // One clock: observe at the falling edge, then return 1 time unit after the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clock);
    last_acc = 1'b0;
    if (out_valid) begin
      check("out_has_word", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        check("dataout", 32'(dataout), 32'(q[0].d));
        check("out_err", 32'(out_err), 32'(q[0].e));
        if (out_ready) void'(q.pop_front());
      end
    end
    if (in_valid && in_ready && rst_n) begin
      last_acc = 1'b1;
      e = ref_word(codein, en_flag, fns_w);
      q.push_back(e);
      if (e.e != 0 && model_errs < 255) model_errs++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [NBITS-1:0] c, input logic [NBITS-1:0] e);
    in_valid = 1'b1; codein = c; en_flag = e;
    for (int k = 0; k < 100; k++) begin
      cycle();
      if (last_acc) break;
    end
    if (!last_acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 50 && q.size() > 0; k++) cycle();
    check("drain_empty", 32'(q.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; codein = '0; en_flag = '0;
    out_ready = 1'b1; clr_err = 1'b0;
    set_fib(21);
    #12;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_dataout", 32'(dataout), 0);
    check("rst_out_err", 32'(out_err), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    #5 rst_n = 1'b1;
    @(posedge clock); #1;

    // Two-clock latency and the reference value for 8'hA5.
    in_valid = 1'b1; codein = 8'hA5; en_flag = 8'hFF;
    cycle();
    in_valid = 1'b0;
    check("lat_edge1_valid", 32'(out_valid), 0);
    cycle();
    check("lat_edge2_valid", 32'(out_valid), 1);
    check("a5_dataout", 32'(dataout), 32);
    check("a5_err", 32'(out_err), 0);
    drain();

    send(8'hA5, 8'h7F);
    send(8'h00, 8'hFF);
    send(8'hFF, 8'h00);
    drain();

    // Out-of-range sum 93.
    set_fib(60);
    send(8'hFF, 8'hFF);
    send(8'hFF, 8'h7F);
    drain();
    check("err_cnt_one", 32'(err_cnt), 1);

    // Four back-to-back words at full throughput.
    set_fib(21);
    for (int k = 0; k < 6; k++) begin
      in_valid = (k < 4);
      codein = 8'($urandom); en_flag = 8'hFF;
      cycle();
      if (k >= 1 && k <= 4) check("b2b_valid", 32'(out_valid), 1);
      if (k == 5) check("b2b_end_valid", 32'(out_valid), 0);
    end
    in_valid = 1'b0;
    drain();

    // Consumer stall: two accepts then backpressure, output held.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      if (k < 2) begin codein = 8'($urandom); en_flag = 8'($urandom); end
      check("stall_in_ready", 32'(in_ready), (k < 2) ? 1 : 0);
      cycle();
    end
    out_ready = 1'b1;
    send(codein, en_flag);
    drain();

    // Saturation at all-ones.
    clr_err = 1'b1; cycle(); clr_err = 1'b0; model_errs = 0;
    check("clr_err_cnt", 32'(err_cnt), 0);
    set_fib(60);
    in_valid = 1'b1; codein = 8'hFF; en_flag = 8'hFF;
    for (int k = 0; k < 255; k++) cycle();
    drain();
    check("err_cnt_255", 32'(err_cnt), 255);
    send(8'hFF, 8'hFF);
    drain();
    check("err_cnt_sat", 32'(err_cnt), 255);

    // Clear coinciding with an error word entering stage 2.
    in_valid = 1'b1; codein = 8'hFF; en_flag = 8'hFF;
    cycle();
    in_valid = 1'b0; clr_err = 1'b1;
    cycle();
    clr_err = 1'b0; model_errs = 0;
    check("clr_priority", 32'(err_cnt), 0);
    drain();
    check("clr_after_drain", 32'(err_cnt), 0);

    // Reset with both stages full.
    out_ready = 1'b0;
    send(8'hFF, 8'hFF);
    send(8'hFF, 8'hFF);
    check("full_in_ready", 32'(in_ready), 0);
    check("full_err_cnt", 32'(err_cnt), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_err_cnt", 32'(err_cnt), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
    q.delete(); model_errs = 0;
    @(negedge clock); rst_n = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; codein = 8'h0F; en_flag = 8'hFF;
    cycle();
    in_valid = 1'b0;
    check("post_rst_edge1_valid", 32'(out_valid), 0);
    cycle();
    check("post_rst_edge2_valid", 32'(out_valid), 1);
    check("post_rst_dataout", 32'(dataout), 7);
    drain();

    // Randomized traffic with changing weights, masks and backpressure.
    clr_err = 1'b1; cycle(); clr_err = 1'b0; model_errs = 0;
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < NBITS; i++) w[i] = int'($urandom_range(0, 31));
      fns_w = pack_w();
      in_valid = ($urandom_range(0, 3) != 0);
      codein = 8'($urandom); en_flag = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    drain();
    check("rand_err_cnt", 32'(err_cnt), 32'(model_errs));
    check("final_queue", 32'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
